// File: rtl/imem_arb_pkg.sv
// Shared types, default geometry and the address legality check for the
// instruction-memory arbiter.
package imem_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef enum logic {
        OWN_F = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    localparam logic [29:0] DEF_BASE_WORD = 30'h00100000;
    localparam int unsigned DEF_DEPTH     = 257;
    localparam int unsigned DEF_LAT       = 1;

    // Word bounds are widened to 31 bits so BASE_WORD+DEPTH-1 cannot wrap.
    function automatic logic addr_bad(input logic [31:0] addr,
                                      input logic [29:0] base_word,
                                      input int unsigned depth);
        logic [30:0] word;
        logic [30:0] lo;
        logic [30:0] hi;
        word = {1'b0, addr[31:2]};
        lo   = {1'b0, base_word};
        hi   = lo + 31'(depth) - 31'd1;
        return (addr[1:0] != 2'b00) || (word < lo) || (word > hi);
    endfunction

endpackage

// File: rtl/imem_arb_rr.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the
// requester that did not own the previous access.
module imem_arb_rr
    import imem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  owner_t     last_owner,
    output logic [1:0] grant,
    output owner_t     winner
);

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        winner = OWN_F;
        grant  = 2'b00;
        if (req == 2'b11) begin
            winner = (last_owner == OWN_F) ? OWN_D : OWN_F;
        end else if (req == 2'b10) begin
            winner = OWN_D;
        end
        if (req != 2'b00) begin
            grant = (winner == OWN_D) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Shares the single instruction-memory read port between fetch (F) and the
// secondary reader (D). Define IMEM_ARB_STATS_EN to build the access counters.
module imem_arbiter
    import imem_arb_pkg::*;
#(
    parameter logic [29:0] BASE_WORD = DEF_BASE_WORD,
    parameter int unsigned DEPTH     = DEF_DEPTH,
    parameter int unsigned LAT       = DEF_LAT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        f_req,
    input  logic [31:0] f_addr,
    output logic        f_gnt,
    output logic        f_valid,
    output logic [31:0] f_rdata,
    output logic        f_err,
    input  logic        d_req,
    input  logic [31:0] d_addr,
    output logic        d_gnt,
    output logic        d_valid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic [31:0] stat_f_cnt,
    output logic [31:0] stat_d_cnt,
    output logic [31:0] stat_conflict_cnt
);

    localparam logic [3:0] LAT_CNT = 4'(LAT);

    state_t      state;
    owner_t      owner;
    owner_t      last_owner;
    owner_t      winner;
    logic [3:0]  cnt;
    logic        err_q;
    logic [1:0]  grant;
    logic        can_grant;
    logic [31:0] win_addr;
    logic [31:0] load_data;
    logic        done;

    imem_arb_rr u_rr (
        .req        ({d_req, f_req}),
        .last_owner (last_owner),
        .grant      (grant),
        .winner     (winner)
    );

    // Grants are withheld while reset is asserted so nothing is accepted then.
    assign can_grant = (state == IDLE) && !reset;
    assign f_gnt     = can_grant && grant[0];
    assign d_gnt     = can_grant && grant[1];
    assign busy      = (state == BUSY);
    assign win_addr  = (winner == OWN_D) ? d_addr : f_addr;
    assign load_data = err_q ? 32'd0 : mem_rdata;
    assign done      = (state == BUSY) && (cnt == 4'd1);

    // NOTE: sequential state uses nonblocking assignments only, so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWN_F;
            last_owner <= OWN_D;
            cnt        <= 4'd0;
            err_q      <= 1'b0;
            mem_addr   <= 32'd0;
            f_valid    <= 1'b0;
            f_rdata    <= 32'd0;
            f_err      <= 1'b0;
            d_valid    <= 1'b0;
            d_rdata    <= 32'd0;
            d_err      <= 1'b0;
        end else begin
            f_valid <= 1'b0;
            d_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        mem_addr   <= win_addr;
                        owner      <= winner;
                        err_q      <= addr_bad(win_addr, BASE_WORD, DEPTH);
                        cnt        <= LAT_CNT;
                        last_owner <= winner;
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= IDLE;
                        if (owner == OWN_F) begin
                            f_valid <= 1'b1;
                            f_rdata <= load_data;
                            f_err   <= err_q;
                        end else begin
                            d_valid <= 1'b1;
                            d_rdata <= load_data;
                            d_err   <= err_q;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IMEM_ARB_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_f_cnt        <= 32'd0;
            stat_d_cnt        <= 32'd0;
            stat_conflict_cnt <= 32'd0;
        end else begin
            if (done && owner == OWN_F) stat_f_cnt <= stat_f_cnt + 32'd1;
            if (done && owner == OWN_D) stat_d_cnt <= stat_d_cnt + 32'd1;
            if (state == IDLE && f_req && d_req) begin
                stat_conflict_cnt <= stat_conflict_cnt + 32'd1;
            end
        end
    end
`else
    logic unused_done;
    assign unused_done       = done;
    assign stat_f_cnt        = 32'd0;
    assign stat_d_cnt        = 32'd0;
    assign stat_conflict_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed scenarios on LAT=1 and LAT=4
// instances plus a randomized run against a transaction-level model.
module tb_imem_arbiter;

    localparam logic [31:0] BASE_W = 32'h00100000;
    localparam int          LAT1   = 1;
    localparam int          LAT4   = 4;
`ifdef IMEM_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        f_req = 1'b0, d_req = 1'b0;
    logic [31:0] f_addr = '0, d_addr = '0;
    logic        f_gnt, d_gnt, f_valid, d_valid, f_err, d_err, busy;
    logic [31:0] f_rdata, d_rdata, mem_addr, mem_rdata;
    logic [31:0] stat_f_cnt, stat_d_cnt, stat_conflict_cnt;

    logic        l4_f_req = 1'b0, l4_d_req = 1'b0;
    logic [31:0] l4_f_addr = '0, l4_d_addr = '0;
    logic        l4_f_gnt, l4_d_gnt, l4_f_valid, l4_d_valid, l4_f_err, l4_d_err, l4_busy;
    logic [31:0] l4_f_rdata, l4_d_rdata, l4_mem_addr, l4_mem_rdata;
    logic [31:0] l4_stat_f, l4_stat_d, l4_stat_c;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h00400000) return 32'h2408000A;
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ a[15:0]};
    endfunction

    assign mem_rdata    = mem_fn(mem_addr);
    assign l4_mem_rdata = mem_fn(l4_mem_addr);

    imem_arbiter #(.LAT(LAT1)) u_dut1 (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_valid(f_valid),
        .f_rdata(f_rdata), .f_err(f_err),
        .d_req(d_req), .d_addr(d_addr), .d_gnt(d_gnt), .d_valid(d_valid),
        .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .busy(busy),
        .stat_f_cnt(stat_f_cnt), .stat_d_cnt(stat_d_cnt),
        .stat_conflict_cnt(stat_conflict_cnt)
    );

    imem_arbiter #(.LAT(LAT4)) u_dut4 (
        .clk(clk), .reset(reset),
        .f_req(l4_f_req), .f_addr(l4_f_addr), .f_gnt(l4_f_gnt), .f_valid(l4_f_valid),
        .f_rdata(l4_f_rdata), .f_err(l4_f_err),
        .d_req(l4_d_req), .d_addr(l4_d_addr), .d_gnt(l4_d_gnt), .d_valid(l4_d_valid),
        .d_rdata(l4_d_rdata), .d_err(l4_d_err),
        .mem_addr(l4_mem_addr), .mem_rdata(l4_mem_rdata), .busy(l4_busy),
        .stat_f_cnt(l4_stat_f), .stat_d_cnt(l4_stat_d), .stat_conflict_cnt(l4_stat_c)
    );

    // Reference rules: legal words are BASE_W .. BASE_W+256, word aligned.
    function automatic bit exp_err(input logic [31:0] a);
        return (a % 4 != 0) || (a / 4 < BASE_W) || (a / 4 >= BASE_W + 32'd257);
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] w;
        w = BASE_W + 32'($urandom_range(0, 256));
        case ($urandom_range(0, 5))
            3: w = ($urandom_range(0, 1) != 0) ? BASE_W : BASE_W + 32'd256;
            4: return (w << 2) | 32'($urandom_range(1, 3));
            5: return ($urandom_range(0, 1) != 0) ? ((BASE_W - 32'd1) << 2)
                                                  : ((BASE_W + 32'd257) << 2);
            default: ;
        endcase
        return w << 2;
    endfunction

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic do_reset();
        f_req = 1'b0; d_req = 1'b0; l4_f_req = 1'b0; l4_d_req = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        sample();
        n_total++; if ({f_gnt, d_gnt, f_valid, d_valid, busy, f_err, d_err} !== 7'b0)
            $display("FAIL reset_flags: got %b want 0", {f_gnt, d_gnt, f_valid, d_valid, busy, f_err, d_err}); else n_pass++;
        n_total++; if (mem_addr !== 32'd0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else n_pass++;
        n_total++; if ({f_rdata, d_rdata} !== 64'd0) $display("FAIL reset_rdata: got %h want 0", {f_rdata, d_rdata}); else n_pass++;
        n_total++; if ({stat_f_cnt, stat_d_cnt, stat_conflict_cnt} !== 96'd0)
            $display("FAIL reset_stats: got %h want 0", {stat_f_cnt, stat_d_cnt, stat_conflict_cnt}); else n_pass++;
        n_total++; if ({l4_busy, l4_f_valid, l4_d_valid, l4_mem_addr} !== 35'd0)
            $display("FAIL reset_l4: got %h want 0", {l4_busy, l4_f_valid, l4_d_valid, l4_mem_addr}); else n_pass++;
    endtask

    task automatic test_single_fetch();
        drive_edge(); f_req = 1'b1; f_addr = 32'h00400000;
        sample();
        n_total++; if ({f_gnt, d_gnt, busy} !== 3'b100) $display("FAIL single_gnt: got %b want 100", {f_gnt, d_gnt, busy}); else n_pass++;
        drive_edge(); f_req = 1'b0; f_addr = $urandom();
        sample();
        n_total++; if (mem_addr !== 32'h00400000) $display("FAIL single_mem_addr: got %h want 00400000", mem_addr); else n_pass++;
        n_total++; if ({busy, f_valid, f_gnt} !== 3'b100) $display("FAIL single_busy: got %b want 100", {busy, f_valid, f_gnt}); else n_pass++;
        drive_edge(); sample();
        n_total++; if ({f_valid, d_valid, f_err, busy} !== 4'b1000) $display("FAIL single_valid: got %b want 1000", {f_valid, d_valid, f_err, busy}); else n_pass++;
        n_total++; if (f_rdata !== 32'h2408000A) $display("FAIL single_rdata: got %h want 2408000a", f_rdata); else n_pass++;
        drive_edge(); sample();
        n_total++; if ({f_valid, f_rdata} !== {1'b0, 32'h2408000A}) $display("FAIL single_hold: got %h want 02408000a", {f_valid, f_rdata}); else n_pass++;
    endtask

    task automatic test_alternate();
        logic [1:0] exp_g [0:9];
        logic [1:0] exp_v;
        int n_valid;
        do_reset();
        n_valid = 0;
        for (int c = 0; c < 10; c++) begin
            drive_edge();
            f_req = (c < 8); d_req = (c < 8);
            f_addr = 32'h00400010; d_addr = 32'h00400020;
            // Both held: one grant every LAT+1 cycles, starting with F.
            exp_g[c] = (c < 8 && c % 2 == 0) ? ((c % 4 == 0) ? 2'b01 : 2'b10) : 2'b00;
            exp_v = (c >= 2) ? exp_g[c-2] : 2'b00;
            sample();
            n_total++; if ({d_gnt, f_gnt} !== exp_g[c]) $display("FAIL alt_gnt c=%0d: got %b want %b", c, {d_gnt, f_gnt}, exp_g[c]); else n_pass++;
            n_total++; if ({d_valid, f_valid} !== exp_v) $display("FAIL alt_valid c=%0d: got %b want %b", c, {d_valid, f_valid}, exp_v); else n_pass++;
            if (f_valid) begin
                n_total++; if (f_rdata !== mem_fn(32'h00400010)) $display("FAIL alt_f_rdata: got %h want %h", f_rdata, mem_fn(32'h00400010)); else n_pass++;
            end
            if (d_valid) begin
                n_total++; if (d_rdata !== mem_fn(32'h00400020)) $display("FAIL alt_d_rdata: got %h want %h", d_rdata, mem_fn(32'h00400020)); else n_pass++;
            end
            n_valid += int'(f_valid) + int'(d_valid);
        end
        n_total++; if (n_valid != 4) $display("FAIL alt_count: got %0d want 4", n_valid); else n_pass++;
        n_total++; if (stat_conflict_cnt !== (STATS ? 32'd4 : 32'd0)) $display("FAIL alt_conflict: got %0d want %0d", stat_conflict_cnt, STATS ? 4 : 0); else n_pass++;
        n_total++; if ({stat_f_cnt, stat_d_cnt} !== (STATS ? {32'd2, 32'd2} : 64'd0)) $display("FAIL alt_stats: got %0d/%0d", stat_f_cnt, stat_d_cnt); else n_pass++;
    endtask

    task automatic test_errors();
        logic [31:0] addrs [0:2];
        int k;
        addrs[0] = 32'h00400402; addrs[1] = 32'h00400404; addrs[2] = 32'h003FFFFC;
        for (int i = 0; i < 3; i++) begin
            drive_edge(); d_req = 1'b1; d_addr = addrs[i];
            sample();
            n_total++; if (d_gnt !== 1'b1) $display("FAIL err_gnt %0d: got %b want 1", i, d_gnt); else n_pass++;
            for (k = 1; k <= 10; k++) begin
                drive_edge(); d_req = 1'b0;
                sample();
                if (k == 1) begin
                    n_total++; if (mem_addr !== addrs[i]) $display("FAIL err_mem_addr %0d: got %h want %h", i, mem_addr, addrs[i]); else n_pass++;
                end
                if (d_valid) break;
            end
            n_total++; if (k != LAT1 + 1) $display("FAIL err_latency %0d: got %0d want %0d", i, k, LAT1 + 1); else n_pass++;
            n_total++; if ({d_err, d_rdata} !== {1'b1, 32'd0}) $display("FAIL err_result %0d: got err=%b rdata=%h want err=1 rdata=0", i, d_err, d_rdata); else n_pass++;
        end
    endtask

    task automatic test_lat4();
        drive_edge(); l4_f_req = 1'b1; l4_f_addr = 32'h00400400;
        sample();
        n_total++; if (l4_f_gnt !== 1'b1) $display("FAIL lat4_gnt: got %b want 1", l4_f_gnt); else n_pass++;
        for (int k = 1; k <= 11; k++) begin
            drive_edge();
            l4_f_req = 1'b0;
            if (k == 2) begin l4_d_req = 1'b1; l4_d_addr = 32'h00400100; end
            if (k == 6) l4_d_req = 1'b0;
            sample();
            n_total++; if (l4_busy !== ((k >= 1 && k <= 4) || (k >= 6 && k <= 9)))
                $display("FAIL lat4_busy k=%0d: got %b", k, l4_busy); else n_pass++;
            n_total++; if ({l4_f_gnt, l4_d_gnt} !== {1'b0, k == 5}) $display("FAIL lat4_d_gnt k=%0d: got %b", k, {l4_f_gnt, l4_d_gnt}); else n_pass++;
            n_total++; if ({l4_f_valid, l4_d_valid} !== {k == 5, k == 10}) $display("FAIL lat4_valid k=%0d: got %b", k, {l4_f_valid, l4_d_valid}); else n_pass++;
            if (k == 5) begin
                n_total++; if ({l4_f_err, l4_f_rdata} !== {1'b0, mem_fn(32'h00400400)}) $display("FAIL lat4_f_data: got %h", {l4_f_err, l4_f_rdata}); else n_pass++;
            end
            if (k == 10) begin
                n_total++; if ({l4_d_err, l4_d_rdata} !== {1'b0, mem_fn(32'h00400100)}) $display("FAIL lat4_d_data: got %h", {l4_d_err, l4_d_rdata}); else n_pass++;
            end
        end
    endtask

    task automatic test_reset_busy();
        do_reset();
        drive_edge(); f_req = 1'b1; f_addr = 32'h00400008;
        sample();
        n_total++; if (f_gnt !== 1'b1) $display("FAIL rb_gnt: got %b want 1", f_gnt); else n_pass++;
        drive_edge(); f_req = 1'b0; reset = 1'b1;
        sample();
        n_total++; if ({busy, f_valid, d_valid, f_gnt, d_gnt, mem_addr} !== 37'd0)
            $display("FAIL rb_cleared: got %h want 0", {busy, f_valid, d_valid, f_gnt, d_gnt, mem_addr}); else n_pass++;
        drive_edge(); sample();
        n_total++; if (f_valid !== 1'b0) $display("FAIL rb_no_valid: got %b want 0", f_valid); else n_pass++;
        drive_edge(); reset = 1'b0; d_req = 1'b1; d_addr = 32'h00400030;
        sample();
        n_total++; if ({f_gnt, d_gnt} !== 2'b01) $display("FAIL rb_d_first: got %b want 01", {f_gnt, d_gnt}); else n_pass++;
        for (int k = 1; k <= 3; k++) begin
            drive_edge(); d_req = 1'b0;
            sample();
            n_total++; if ({f_valid, d_valid} !== {1'b0, k == 2}) $display("FAIL rb_after k=%0d: got %b", k, {f_valid, d_valid}); else n_pass++;
        end
    endtask

    task automatic test_idle();
        logic [31:0] m0;
        logic [95:0] s0;
        m0 = mem_addr;
        s0 = {stat_f_cnt, stat_d_cnt, stat_conflict_cnt};
        for (int k = 0; k < 10; k++) begin
            drive_edge(); sample();
            n_total++; if ({mem_addr, f_valid, d_valid, busy} !== {m0, 3'b000})
                $display("FAIL idle k=%0d: got %h want %h", k, {mem_addr, f_valid, d_valid, busy}, {m0, 3'b000}); else n_pass++;
        end
        n_total++; if ({stat_f_cnt, stat_d_cnt, stat_conflict_cnt} !== s0) $display("FAIL idle_stats: got %h want %h",
            {stat_f_cnt, stat_d_cnt, stat_conflict_cnt}, s0); else n_pass++;
    endtask

    typedef struct {
        int          cyc;
        bit          own;
        logic [31:0] data;
        bit          err;
    } cpl_t;

    task automatic test_random();
        cpl_t q[$];
        cpl_t e;
        int free_at, n_f, n_d, n_conf;
        bit last, f_pend, d_pend, efv, edv, efg, edg, win;
        logic [31:0] fa, da, a, exp_mem, f_rd, d_rd;
        bit f_er, d_er;
        do_reset();
        free_at = 0; last = 1'b1; exp_mem = '0;
        f_rd = '0; d_rd = '0; f_er = 1'b0; d_er = 1'b0;
        n_f = 0; n_d = 0; n_conf = 0; f_pend = 1'b0; d_pend = 1'b0; fa = '0; da = '0;
        for (int c = 0; c < 400; c++) begin
            drive_edge();
            if (c < 380) begin
                if (!f_pend && $urandom_range(0, 2) == 0) begin f_pend = 1'b1; fa = rand_addr(); end
                if (!d_pend && $urandom_range(0, 2) == 0) begin d_pend = 1'b1; da = rand_addr(); end
            end
            f_req = f_pend; f_addr = f_pend ? fa : $urandom();
            d_req = d_pend; d_addr = d_pend ? da : $urandom();
            sample();
            efv = 1'b0; edv = 1'b0; efg = 1'b0; edg = 1'b0;
            if (q.size() != 0 && q[0].cyc == c) begin
                e = q.pop_front();
                if (e.own) begin edv = 1'b1; d_rd = e.data; d_er = e.err; n_d++; end
                else       begin efv = 1'b1; f_rd = e.data; f_er = e.err; n_f++; end
            end
            n_total++; if (busy !== (c < free_at)) $display("FAIL rnd_busy c=%0d: got %b want %b", c, busy, c < free_at); else n_pass++;
            n_total++; if (mem_addr !== exp_mem) $display("FAIL rnd_mem_addr c=%0d: got %h want %h", c, mem_addr, exp_mem); else n_pass++;
            if (c >= free_at && (f_pend || d_pend)) begin
                if (f_pend && d_pend) begin win = !last; n_conf++; end
                else win = d_pend;
                efg = !win; edg = win; last = win;
                a = win ? da : fa;
                free_at = c + LAT1 + 1;
                e.cyc = free_at; e.own = win; e.err = exp_err(a);
                e.data = e.err ? 32'd0 : mem_fn(a);
                q.push_back(e);
                exp_mem = a;
            end
            n_total++; if ({f_gnt, d_gnt} !== {efg, edg}) $display("FAIL rnd_gnt c=%0d: got %b want %b", c, {f_gnt, d_gnt}, {efg, edg}); else n_pass++;
            n_total++; if ({f_valid, d_valid} !== {efv, edv}) $display("FAIL rnd_valid c=%0d: got %b want %b", c, {f_valid, d_valid}, {efv, edv}); else n_pass++;
            n_total++; if ({f_err, f_rdata} !== {f_er, f_rd}) $display("FAIL rnd_f_data c=%0d: got %h want %h", c, {f_err, f_rdata}, {f_er, f_rd}); else n_pass++;
            n_total++; if ({d_err, d_rdata} !== {d_er, d_rd}) $display("FAIL rnd_d_data c=%0d: got %h want %h", c, {d_err, d_rdata}, {d_er, d_rd}); else n_pass++;
            if (efg) f_pend = 1'b0;
            if (edg) d_pend = 1'b0;
        end
        n_total++; if ({stat_f_cnt, stat_d_cnt, stat_conflict_cnt} !== (STATS ? {32'(n_f), 32'(n_d), 32'(n_conf)} : 96'd0))
            $display("FAIL rnd_stats: got %0d/%0d/%0d model %0d/%0d/%0d", stat_f_cnt, stat_d_cnt, stat_conflict_cnt, n_f, n_d, n_conf); else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_fetch();
        test_alternate();
        test_errors();
        test_lat4();
        test_reset_busy();
        test_idle();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
